// File: rtl/link_ctrl.sv
// Frame-level link controller: TX framer (preamble, SFD, payload) toward the MSK modulator
// and RX SFD hunter feeding the output FIFO. Optional RX idle timeout: LINK_CTRL_RX_TIMEOUT_EN.
module link_ctrl #(
    parameter int                   FRAME_BITS    = 64,
    parameter int                   PREAMBLE_BITS = 32,
    parameter int                   SFD_WIDTH     = 8,
    parameter logic [SFD_WIDTH-1:0] SFD           = 8'hA7,
    parameter int                   RX_TIMEOUT    = 1024,
    localparam int                  CNT_W         = $clog2(FRAME_BITS + 1)
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inTxStart,
    input  logic             inFifoEmpty,
    input  logic             inFifoData,
    output logic             outFifoReadEnable,
    input  logic             inCoderReady,
    output logic             outCoderData,
    output logic             outCoderEmpty,
    input  logic             inCdrFlag,
    input  logic             inCdrData,
    input  logic             inOutFifoFull,
    output logic             outOutFifoWriteEnable,
    output logic             outOutFifoData,
    output logic             outTxBusy,
    output logic             outRxBusy,
    output logic             outTxDone,
    output logic             outRxDone,
    output logic             outTxUnderrun,
    output logic             outRxOverflow,
    output logic             outRxAbort,
    output logic [CNT_W-1:0] outRxBitCount
);

    localparam int TX_MAX = (FRAME_BITS > PREAMBLE_BITS)
                          ? ((FRAME_BITS > SFD_WIDTH) ? FRAME_BITS : SFD_WIDTH)
                          : ((PREAMBLE_BITS > SFD_WIDTH) ? PREAMBLE_BITS : SFD_WIDTH);
    localparam int TX_CW  = (TX_MAX > 1) ? $clog2(TX_MAX) : 1;
    localparam int FILL_W = $clog2(SFD_WIDTH + 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_SFD,
        TX_PAYLOAD,
        TX_DONE
    } tx_state_e;

    typedef enum logic {
        RX_HUNT,
        RX_PAYLOAD
    } rx_state_e;

    tx_state_e            tx_state_q;
    logic [TX_CW-1:0]     tx_cnt_q;
    logic                 tx_underrun_q;
    logic [SFD_WIDTH-1:0] sfd_shift;

    rx_state_e            rx_state_q;
    logic [SFD_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [FILL_W-1:0]    rx_fill_q, rx_fill_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic                 rx_match;
    logic                 rx_frame_end;
    logic                 rx_wr_q;
    logic                 rx_data_q;
    logic                 rx_done_q;
    logic                 rx_ovf_q;

    // ---------------------------------------------------------------- TX
    always_ff @(posedge inClock) begin
        if (inReset) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_underrun_q <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (inTxStart) begin
                        tx_state_q    <= TX_PREAMBLE;
                        tx_cnt_q      <= '0;
                        tx_underrun_q <= 1'b0;
                    end
                end
                TX_PREAMBLE: begin
                    if (inCoderReady) begin
                        if (tx_cnt_q == TX_CW'(PREAMBLE_BITS - 1)) begin
                            tx_state_q <= TX_SFD;
                            tx_cnt_q   <= '0;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + TX_CW'(1);
                        end
                    end
                end
                TX_SFD: begin
                    if (inCoderReady) begin
                        if (tx_cnt_q == TX_CW'(SFD_WIDTH - 1)) begin
                            tx_state_q <= TX_PAYLOAD;
                            tx_cnt_q   <= '0;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + TX_CW'(1);
                        end
                    end
                end
                TX_PAYLOAD: begin
                    // A consumed slot with nothing to give is an underrun; the frame just waits.
                    if (inCoderReady) begin
                        if (inFifoEmpty) begin
                            tx_underrun_q <= 1'b1;
                        end else if (tx_cnt_q == TX_CW'(FRAME_BITS - 1)) begin
                            tx_state_q <= TX_DONE;
                            tx_cnt_q   <= '0;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + TX_CW'(1);
                        end
                    end
                end
                TX_DONE: tx_state_q <= TX_IDLE;
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign sfd_shift = SFD << tx_cnt_q;

    always_comb begin
        outCoderData      = 1'b0;
        outCoderEmpty     = 1'b1;
        outFifoReadEnable = 1'b0;
        case (tx_state_q)
            TX_PREAMBLE: begin
                outCoderData  = ~tx_cnt_q[0];
                outCoderEmpty = 1'b0;
            end
            TX_SFD: begin
                outCoderData  = sfd_shift[SFD_WIDTH-1];
                outCoderEmpty = 1'b0;
            end
            TX_PAYLOAD: begin
                outCoderData      = inFifoData;
                outCoderEmpty     = inFifoEmpty;
                outFifoReadEnable = inCoderReady & ~inFifoEmpty;
            end
            default: ;
        endcase
    end

    assign outTxBusy     = (tx_state_q != TX_IDLE);
    assign outTxDone     = (tx_state_q == TX_DONE);
    assign outTxUnderrun = tx_underrun_q;

    // ---------------------------------------------------------------- RX
    always_comb begin
        rx_sr_d      = {rx_sr_q[SFD_WIDTH-2:0], inCdrData};
        rx_fill_d    = (rx_fill_q == FILL_W'(SFD_WIDTH)) ? rx_fill_q : rx_fill_q + FILL_W'(1);
        rx_match     = inCdrFlag && (rx_fill_d == FILL_W'(SFD_WIDTH)) && (rx_sr_d == SFD);
        rx_cnt_d     = rx_cnt_q + CNT_W'(1);
        rx_frame_end = (rx_cnt_d == CNT_W'(FRAME_BITS));
    end

`ifdef LINK_CTRL_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);
    logic [IDLE_W-1:0] rx_idle_q;
    logic              rx_abort_q;
`endif

    always_ff @(posedge inClock) begin
        if (inReset) begin
            rx_state_q <= RX_HUNT;
            rx_sr_q    <= '0;
            rx_fill_q  <= '0;
            rx_cnt_q   <= '0;
            rx_wr_q    <= 1'b0;
            rx_data_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
`ifdef LINK_CTRL_RX_TIMEOUT_EN
            rx_idle_q  <= '0;
            rx_abort_q <= 1'b0;
`endif
        end else begin
            rx_wr_q   <= 1'b0;
            rx_done_q <= 1'b0;
`ifdef LINK_CTRL_RX_TIMEOUT_EN
            rx_abort_q <= 1'b0;
`endif
            case (rx_state_q)
                RX_HUNT: begin
                    if (inCdrFlag) begin
                        rx_sr_q   <= rx_sr_d;
                        rx_fill_q <= rx_fill_d;
                    end
                    if (rx_match) begin
                        rx_state_q <= RX_PAYLOAD;
                        rx_cnt_q   <= '0;
                        rx_ovf_q   <= 1'b0;
`ifdef LINK_CTRL_RX_TIMEOUT_EN
                        rx_idle_q  <= IDLE_W'(1);
`endif
                    end
                end
                RX_PAYLOAD: begin
                    if (inCdrFlag) begin
                        rx_cnt_q <= rx_cnt_d;
                        if (!inOutFifoFull) begin
                            rx_wr_q   <= 1'b1;
                            rx_data_q <= inCdrData;
                        end else begin
                            rx_ovf_q <= 1'b1;
                        end
                        if (rx_frame_end) begin
                            rx_state_q <= RX_HUNT;
                            rx_sr_q    <= '0;
                            rx_fill_q  <= '0;
                            rx_done_q  <= 1'b1;
                        end
`ifdef LINK_CTRL_RX_TIMEOUT_EN
                        // Holds the number of cycles elapsed since the last flag, so it is 1 next cycle.
                        rx_idle_q <= IDLE_W'(1);
                    end else if (rx_idle_q >= IDLE_W'(RX_TIMEOUT - 1)) begin
                        rx_state_q <= RX_HUNT;
                        rx_sr_q    <= '0;
                        rx_fill_q  <= '0;
                        rx_abort_q <= 1'b1;
                    end else begin
                        rx_idle_q <= rx_idle_q + IDLE_W'(1);
`endif
                    end
                end
                default: rx_state_q <= RX_HUNT;
            endcase
        end
    end

`ifdef LINK_CTRL_RX_TIMEOUT_EN
    assign outRxAbort = rx_abort_q;
`else
    assign outRxAbort = 1'b0;
`endif

    assign outRxBusy             = (rx_state_q == RX_PAYLOAD);
    assign outRxDone             = rx_done_q;
    assign outRxOverflow         = rx_ovf_q;
    assign outOutFifoWriteEnable = rx_wr_q;
    assign outOutFifoData        = rx_data_q;
    assign outRxBitCount         = rx_cnt_q;

endmodule
